// File: rtl/tcm_mem_ctrl_pkg.sv
// Shared types and width helpers for the tightly-coupled memory controller.
package tcm_pkg;

  localparam int RL_MIN     = 1;
  localparam int RL_MAX     = 3;
  localparam int DEF_DATA_W = 32;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
  } tcm_rsp_t;

  function automatic int bank_sel_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 0;
  endfunction

  function automatic int row_w(input int depth, input int num_banks);
    return ((depth / num_banks) > 1) ? $clog2(depth / num_banks) : 1;
  endfunction

  function automatic int cnt_w(input int rsp_depth);
    return $clog2(rsp_depth + 1);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/tcm_mem_ctrl_rsp_fifo.sv
// In-order response queue with wrap-around pointers; the head is valid whenever count is non-zero.
module tcm_rsp_fifo
  import tcm_pkg::*;
#(
  parameter type T          = tcm_rsp_t,
  parameter int  DEPTH      = 4,
  localparam int CNT_W      = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/tcm_mem_ctrl.sv
// Banked TCM with req/gnt handshake, fixed read latency and a fall-through in-order response queue.
module tcm_mem_ctrl
  import tcm_pkg::*;
#(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 12,
  parameter int    DEPTH        = 4096,
  parameter int    NUM_BANKS    = 2,
  parameter int    READ_LATENCY = 1,
  parameter int    RSP_DEPTH    = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int BANK_SEL_W = bank_sel_w(NUM_BANKS);
  localparam int ROWS       = DEPTH / NUM_BANKS;
  localparam int ROW_W      = row_w(DEPTH, NUM_BANKS);
  localparam int CNT_W      = cnt_w(RSP_DEPTH);
  localparam int BYTES      = DATA_WIDTH / 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_t;

  if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_bad_latency
    $fatal(1, "tcm_mem_ctrl: READ_LATENCY must be within 1..3");
  end
  if (RSP_DEPTH < READ_LATENCY) begin : g_bad_rsp_depth
    $fatal(1, "tcm_mem_ctrl: RSP_DEPTH must be >= READ_LATENCY");
  end
  if (DEPTH % NUM_BANKS != 0) begin : g_bad_depth
    $fatal(1, "tcm_mem_ctrl: DEPTH must be a multiple of NUM_BANKS");
  end
  if (!is_pow2(NUM_BANKS)) begin : g_bad_banks
    $fatal(1, "tcm_mem_ctrl: NUM_BANKS must be a power of 2");
  end

  logic [CNT_W-1:0]                      outstanding;
  logic                                  accept;
  logic                                  pop;
  logic                                  in_range;
  logic [ROW_W-1:0]                      row;
  logic [NUM_BANKS-1:0]                  bank_en;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rd;
  logic [DATA_WIDTH-1:0]                 rd_or;
  logic [READ_LATENCY-1:0]               vld_p;
  logic                                  err_p0;
  logic                                  wack_p0;
  logic [NUM_BANKS-1:0]                  en_p0;
  rsp_t                                  rsp_p0;
  rsp_t                                  pipe_rsp;
  logic                                  pipe_vld;
  rsp_t                                  fifo_head;
  rsp_t                                  head;
  logic                                  fifo_push;
  logic                                  fifo_pop;
  logic                                  fifo_full;
  logic                                  fifo_empty;
  logic [CNT_W-1:0]                      fifo_count;
  logic                                  unused_fifo_status;

  assign gnt_o    = (outstanding < CNT_W'(RSP_DEPTH));
  assign accept   = req_i && gnt_o;
  assign in_range = (64'(addr_i) < 64'(DEPTH));
  assign row      = ROW_W'(addr_i >> BANK_SEL_W);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else if (accept && !pop) begin
      outstanding <= outstanding + 1'b1;
    end else if (!accept && pop) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [DATA_WIDTH-1:0] rd_q;

    initial begin
      for (int r = 0; r < ROWS; r++) mem[r] = '0;
    end

    assign bank_en[b] = accept && in_range &&
                        ((addr_i & ADDR_WIDTH'(NUM_BANKS - 1)) == ADDR_WIDTH'(b));

    always_ff @(posedge clk_i) begin
      if (bank_en[b]) begin
        if (we_i) begin
          for (int i = 0; i < BYTES; i++) begin
            if (be_i[i]) mem[row][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end else begin
          rd_q <= mem[row];
        end
      end
    end

    assign bank_rd[b] = en_p0[b] ? rd_q : '0;
  end

  // p0: bank output registers plus the control that travels with them
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int k = 1; k < READ_LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    err_p0  <= !in_range;
    wack_p0 <= we_i;
    en_p0   <= bank_en;
  end

  always_comb begin
    rd_or = '0;
    for (int b = 0; b < NUM_BANKS; b++) rd_or = rd_or | bank_rd[b];
    rsp_p0.rdata = (err_p0 || wack_p0) ? '0 : rd_or;
    rsp_p0.err   = err_p0;
  end

  // p1..pN: extra delay stages for READ_LATENCY > 1
  if (READ_LATENCY == 1) begin : g_lat1
    assign pipe_rsp = rsp_p0;
    assign pipe_vld = vld_p[0];
  end else begin : g_latn
    rsp_t rsp_q [READ_LATENCY-1];
    always_ff @(posedge clk_i) begin
      rsp_q[0] <= rsp_p0;
      for (int k = 1; k < READ_LATENCY - 1; k++) rsp_q[k] <= rsp_q[k-1];
    end
    assign pipe_rsp = rsp_q[READ_LATENCY-2];
    assign pipe_vld = vld_p[READ_LATENCY-1];
  end

  // Completion bypasses the queue only when it is empty and consumed this cycle
  assign fifo_push = pipe_vld && !(fifo_empty && rready_i);
  assign rvalid_o  = !fifo_empty || pipe_vld;
  assign pop       = rvalid_o && rready_i;
  assign fifo_pop  = pop && !fifo_empty;
  assign head      = fifo_empty ? pipe_rsp : fifo_head;
  assign rdata_o   = rvalid_o ? head.rdata : '0;
  assign err_o     = rvalid_o && head.err;

  tcm_rsp_fifo #(
    .T     (rsp_t),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (fifo_push),
    .push_data (pipe_rsp),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_fifo_status = ^{fifo_full, fifo_count};

endmodule
